multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Parametrised multi-cycle control sequencer for the RV32I core. Owns the program counter, the instruction register, the per-instruction state machine and the retired-instruction counter. Drives instruction and data memory through req/ready handshakes with a wait-state timeout. Emits Moore-style control strobes to the register file, ALU source mux and write-back mux, so that one shared ALU, adder and memory port serve all instruction phases.

## Interface
Parameters:
- XLEN, 32: PC and target width.
- RESET_PC, 0: PC value loaded on reset.
- TIMEOUT, 15: maximum wait cycles on either memory handshake before FAULT; 0 disables the timeout.
- CNT_W, 32: retired-instruction counter width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  XLEN  fetch address; equals pc.
- imem_rdata  in  32  fetched instruction.
- imem_ready  in  1  fetch complete; imem_rdata valid this cycle.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid only with dmem_req.
- dmem_ready  in  1  data access complete.
- branch_cond  in  1  branch-taken result from the ALU comparator.
- target_in  in  XLEN  branch/JAL/JALR target from the external imm_gen plus adder path.
- pc  out  XLEN  current PC.
- ir  out  32  instruction register.
- reg_write  out  1  register file write enable.
- alu_src_imm  out  1  1 selects the immediate as ALU operand B.
- wb_sel  out  2  write-back source: 0 ALU, 1 memory, 2 pc+4.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  CNT_W  retired-instruction count; wraps modulo 2^CNT_W.
- fault  out  1  high in FAULT.

## Operation
- Decode uses ir[6:0]:
  - ALU class: R 0110011, I 0010011, LUI 0110111, AUIPC 0010111.
  - LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111.
  - SYSTEM 1110011.
  - Any other opcode is illegal.
- FETCH:
  - imem_req=1 until imem_ready.
  - On imem_ready: ir<=imem_rdata, go to DECODE.
- DECODE (1 cycle):
  - illegal opcode goes to FAULT.
  - SYSTEM goes to HALT.
  - Otherwise go to EXEC.
- EXEC (1 cycle):
  - LOAD/STORE go to MEM.
  - BRANCH: pc<=branch_cond ? target_in : pc+4; pulse retire; go to FETCH.
  - Others go to WB.
- MEM:
  - dmem_req=1 and dmem_we=(STORE) until dmem_ready.
  - STORE: pc<=pc+4, retire, go to FETCH.
  - LOAD: go to WB.
- WB (1 cycle):
  - reg_write=1.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - pc<=(JAL|JALR) ? target_in : pc+4; retire; go to FETCH.
- Target alignment:
  - For JALR, target_in bit 0 is cleared before use.
  - Any taken target with bit 1 (or, for non-JALR targets, bit 0) set goes to FAULT with pc unchanged and no retire.
- alu_src_imm=1 in EXEC/MEM/WB for every class except R-type and BRANCH.
- Control outputs decode from state and ir only (no input paths to outputs except through registers).
- Timeout:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle ready is low.
  - When TIMEOUT≠0 and the counter equals TIMEOUT with ready still low, go to FAULT on that edge.
  - ready arriving in the same cycle as the limit wins: the access completes.
- HALT and FAULT are absorbing: no requests, no retire, pc/ir/instret frozen; only reset exits.
- instret increments on each retire pulse.

## Timing
- Reset (rst_n low, asynchronous):
  - state=FETCH, pc=RESET_PC, ir=32'h00000013, instret=0, wait counter=0.
  - fault=0, retire=0, reg_write=0, dmem_req=0, dmem_we=0, alu_src_imm=0, wb_sel=0.
  - imem_req is forced 0 while rst_n=0 and rises combinationally once rst_n is high.
- Zero-wait cycles per instruction: ALU/JAL/JALR 4, LOAD 5, STORE 4, BRANCH 3. Each wait cycle on imem_ready or dmem_ready adds 1.
- retire is asserted in the cycle whose rising edge commits the new pc.
- Requests are held stable (addr, we) until the cycle ready is sampled high; they drop the cycle after.
- Reset asserted mid-instruction aborts it: no retire, no reg_write after rst_n falls; fetch restarts at RESET_PC.

## Test plan
- Reset release with imem_ready=1, ir fed 0x00500093 (addi x1,x0,5) -> states 0,1,2,4; reg_write high in cycle 4 with wb_sel=0 and alu_src_imm=1; pc=4; instret=1.
- LOAD 0x00002103 with dmem_ready delayed 3 cycles -> 8 cycles total; dmem_we=0; WB has wb_sel=1; pc+4.
- BRANCH with branch_cond=1, target_in=0x40 -> 3 cycles, pc=0x40, retire once; then target_in=0x42 -> FAULT, pc held.
- JALR with target_in=0x101 -> pc=0x100, wb_sel=2; JAL with target_in=0x102 -> FAULT.
- TIMEOUT=15, imem_ready held low -> FAULT on the 15th wait edge; ready high on that same cycle -> DECODE instead.
- Illegal opcode 0x0000007F -> FAULT after DECODE; SYSTEM 0x00000073 -> HALT, instret frozen; rst_n pulse low mid-MEM -> pc=RESET_PC, instret=0, dmem_req=0 immediately.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: RV32I multi-cycle control FSM owning pc, ir, wait counter and instret.
// Latency: ALU/JAL/JALR 4, STORE 4, LOAD 5, BRANCH 3 cycles, plus one per memory wait cycle.
// Backpressure: imem/dmem requests held until ready; TIMEOUT consecutive wait cycles -> FAULT.
module multicycle_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    input  logic             branch_cond,
    input  logic [XLEN-1:0]  target_in,
    output logic [XLEN-1:0]  pc,
    output logic [31:0]      ir,
    output logic             reg_write,
    output logic             alu_src_imm,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             fault
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int              WAIT_W   = $clog2(TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [31:0]       ir_q;
    logic [CNT_W-1:0]  instret_q;
    logic [WAIT_W-1:0] wait_cnt;

    logic [6:0] opc;
    logic is_r, is_i, is_lui, is_auipc, is_load, is_store;
    logic is_branch, is_jal, is_jalr, is_system, is_legal, is_jump;

    assign opc       = ir_q[6:0];
    assign is_r      = (opc == OP_R);
    assign is_i      = (opc == OP_I);
    assign is_lui    = (opc == OP_LUI);
    assign is_auipc  = (opc == OP_AUIPC);
    assign is_load   = (opc == OP_LOAD);
    assign is_store  = (opc == OP_STORE);
    assign is_branch = (opc == OP_BRANCH);
    assign is_jal    = (opc == OP_JAL);
    assign is_jalr   = (opc == OP_JALR);
    assign is_system = (opc == OP_SYSTEM);
    assign is_jump   = is_jal | is_jalr;
    assign is_legal  = is_r | is_i | is_lui | is_auipc | is_load | is_store |
                       is_branch | is_jal | is_jalr | is_system;

    logic [XLEN-1:0] pc_plus4, jalr_tgt, jump_tgt;
    logic            jump_misalign, waiting, wait_expire;
    logic            commit, fault_go;
    logic [XLEN-1:0] pc_next;

    assign pc_plus4      = pc_q + XLEN'(4);
    assign jalr_tgt      = {target_in[XLEN-1:1], 1'b0};
    assign jump_tgt      = is_jalr ? jalr_tgt : target_in;
    assign jump_misalign = is_jalr ? jalr_tgt[1] : (target_in[1:0] != 2'b00);

    assign waiting     = ((state_q == S_FETCH) && !imem_ready) ||
                         ((state_q == S_MEM) && !dmem_ready);
    assign wait_expire = (TIMEOUT != 0) && waiting && (wait_cnt == WAIT_LIM);

    // Commit is the only path that depends on live inputs: a misaligned target
    // must suppress the retire pulse in the same cycle it would have fired.
    always_comb begin
        commit   = 1'b0;
        fault_go = 1'b0;
        pc_next  = pc_q;
        case (state_q)
            S_EXEC: begin
                if (is_branch) begin
                    if (!branch_cond) begin
                        commit  = 1'b1;
                        pc_next = pc_plus4;
                    end else if (target_in[1:0] != 2'b00) begin
                        fault_go = 1'b1;
                    end else begin
                        commit  = 1'b1;
                        pc_next = target_in;
                    end
                end
            end
            S_MEM: begin
                if (dmem_ready && is_store) begin
                    commit  = 1'b1;
                    pc_next = pc_plus4;
                end
            end
            S_WB: begin
                if (!is_jump) begin
                    commit  = 1'b1;
                    pc_next = pc_plus4;
                end else if (jump_misalign) begin
                    fault_go = 1'b1;
                end else begin
                    commit  = 1'b1;
                    pc_next = jump_tgt;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0000_0013;
            instret_q <= '0;
            wait_cnt  <= '0;
        end else begin
            wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
            if (commit) begin
                pc_q      <= pc_next;
                instret_q <= instret_q + 1'b1;
            end
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir_q    <= imem_rdata;
                        state_q <= S_DECODE;
                    end else if (wait_expire) begin
                        state_q <= S_FAULT;
                    end
                end
                S_DECODE: begin
                    if (!is_legal)      state_q <= S_FAULT;
                    else if (is_system) state_q <= S_HALT;
                    else                state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_load || is_store) state_q <= S_MEM;
                    else if (is_branch)      state_q <= fault_go ? S_FAULT : S_FETCH;
                    else                     state_q <= S_WB;
                end
                S_MEM: begin
                    if (dmem_ready)       state_q <= is_store ? S_FETCH : S_WB;
                    else if (wait_expire) state_q <= S_FAULT;
                end
                S_WB:    state_q <= fault_go ? S_FAULT : S_FETCH;
                S_HALT:  state_q <= S_HALT;
                S_FAULT: state_q <= S_FAULT;
                default: state_q <= S_FAULT;
            endcase
        end
    end

    assign imem_req    = rst_n && (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign dmem_req    = (state_q == S_MEM);
    assign dmem_we     = dmem_req && is_store;
    assign reg_write   = (state_q == S_WB);
    assign wb_sel      = (state_q != S_WB) ? 2'd0 :
                         is_load           ? 2'd1 :
                         is_jump           ? 2'd2 : 2'd0;
    assign alu_src_imm = ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) &&
                         !is_r && !is_branch;
    assign pc          = pc_q;
    assign ir          = ir_q;
    assign state       = state_q;
    assign retire      = commit;
    assign instret     = instret_q;
    assign fault       = (state_q == S_FAULT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed instructions, scoreboard checked on retire/terminal events.
module tb_multicycle_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        branch_cond;
    logic [31:0] target_in;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        reg_write;
    logic        alu_src_imm;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
    logic        retire;
    logic [31:0] instret;
    logic        fault;

    multicycle_sequencer #(
        .XLEN(32), .RESET_PC(32'h0), .TIMEOUT(15), .CNT_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .branch_cond(branch_cond), .target_in(target_in),
        .pc(pc), .ir(ir), .reg_write(reg_write), .alu_src_imm(alu_src_imm),
        .wb_sel(wb_sel), .state(state), .retire(retire), .instret(instret),
        .fault(fault)
    );

    typedef struct {
        bit          term;
        logic [2:0]  st;
        int          cyc;
        logic [31:0] pc;
        logic [31:0] instret;
        bit          rw;
        logic [1:0]  wbsel;
        bit          imm;
        bit          we;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   ev_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input bit term, input logic [2:0] st, input int cyc,
                                input logic [31:0] epc, input logic [31:0] eret,
                                input bit rw, input logic [1:0] wbsel, input bit imm,
                                input bit we);
        exp_t e;
        e.term = term; e.st = st; e.cyc = cyc; e.pc = epc; e.instret = eret;
        e.rw = rw; e.wbsel = wbsel; e.imm = imm; e.we = we;
        return e;
    endfunction

    // Memory responders: ready after cur_iwait / cur_dwait wait cycles of the access.
    logic [31:0] cur_instr = 32'h0000_0013;
    int cur_iwait = 0, cur_dwait = 0;
    int iw = 0, dw = 0;
    bit was_fetch = 0, was_mem = 0;

    always @(posedge clk) begin
        #1;
        if (!rst_n || state != 3'd0) iw = 0;
        else if (was_fetch)          iw++;
        was_fetch = (state == 3'd0);
        if (!rst_n || state != 3'd3) dw = 0;
        else if (was_mem)            dw++;
        was_mem = (state == 3'd3) && rst_n;
    end

    assign imem_rdata = cur_instr;
    assign imem_ready = (state == 3'd0) && (iw == cur_iwait);
    assign dmem_ready = (state == 3'd3) && (dw == cur_dwait);

    // Monitor: pops one expectation per retire pulse or per entry into HALT/FAULT.
    int   cyc = 0;
    bit   pend = 0, prev_term = 0, seen_we = 0, term_now;
    exp_t pend_e, me;

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc = 0; pend = 0; prev_term = 0; seen_we = 0;
        end else begin
            cyc++;
            if (dmem_req && dmem_we) seen_we = 1;
            if (pend) begin
                chk("pc_after_retire", pc, pend_e.pc);
                chk("instret_after_retire", instret, pend_e.instret);
                pend = 0;
            end
            if (retire) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_retire: got retire at pc=%0h expected none", pc);
                end else begin
                    me = q.pop_front();
                    chk("event_is_terminal", 32'd0, {31'd0, me.term});
                    chk("retire_state", {29'd0, state}, {29'd0, me.st});
                    chk("retire_cycles", cyc, me.cyc);
                    chk("reg_write", {31'd0, reg_write}, {31'd0, me.rw});
                    chk("wb_sel", {30'd0, wb_sel}, {30'd0, me.wbsel});
                    chk("alu_src_imm", {31'd0, alu_src_imm}, {31'd0, me.imm});
                    chk("store_we_seen", {31'd0, seen_we}, {31'd0, me.we});
                    pend_e = me;
                    pend = 1;
                end
                cyc = 0;
                seen_we = 0;
                ev_cnt++;
            end
            term_now = (state == 3'd5) || (state == 3'd6);
            if (term_now && !prev_term) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_terminal: got state=%0d expected none", state);
                end else begin
                    me = q.pop_front();
                    chk("event_is_terminal", 32'd1, {31'd0, me.term});
                    chk("terminal_state", {29'd0, state}, {29'd0, me.st});
                    chk("terminal_cycles", cyc, me.cyc);
                    chk("terminal_pc", pc, me.pc);
                    chk("terminal_instret", instret, me.instret);
                    chk("fault_flag", {31'd0, fault}, {31'd0, me.st == 3'd6});
                end
                ev_cnt++;
            end
            prev_term = term_now;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0000_0013);
        chk("rst_instret", instret, 32'd0);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
        chk("rst_wb_sel", {30'd0, wb_sel}, 32'd0);
        chk("rst_alu_src_imm", {31'd0, alu_src_imm}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("imem_req_after_release", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic issue(input logic [31:0] instr, input int iwait, input int dwait,
                         input logic bcond, input logic [31:0] tgt, input exp_t e);
        int e0;
        cur_instr   = instr;
        cur_iwait   = iwait;
        cur_dwait   = dwait;
        branch_cond = bcond;
        target_in   = tgt;
        q.push_back(e);
        e0 = ev_cnt;
        for (int i = 0; i < 400 && ev_cnt == e0; i++) begin
            @(negedge clk);
            #1;
        end
        if (ev_cnt == e0) begin
            total++; bad++;
            $display("FAIL event_timeout: got no event for instr=%08h expected one", instr);
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADDI   = 32'h0050_0093;
    localparam logic [31:0] LW     = 32'h0000_2103;
    localparam logic [31:0] SW     = 32'h0011_2023;
    localparam logic [31:0] BEQ    = 32'h0000_0063;
    localparam logic [31:0] ADD    = 32'h0020_81B3;
    localparam logic [31:0] JALR   = 32'h0000_80E7;
    localparam logic [31:0] JAL    = 32'h0080_00EF;
    localparam logic [31:0] ILLEG  = 32'h0000_007F;
    localparam logic [31:0] ECALL  = 32'h0000_0073;

    initial begin
        rst_n       = 1'b0;
        branch_cond = 1'b0;
        target_in   = 32'h0;

        do_reset();
        //           instr  iw  dw    bc  tgt                 term st cyc pc        ret rw wb imm we
        issue(ADDI,  0,  0,    0, 32'h0,   mk(0, 4, 4,  32'h4,   1, 1, 0, 1, 0));
        issue(LW,    0,  3,    0, 32'h0,   mk(0, 4, 8,  32'h8,   2, 1, 1, 1, 0));
        issue(SW,    0,  0,    0, 32'h0,   mk(0, 3, 4,  32'hC,   3, 0, 0, 1, 1));
        issue(BEQ,   0,  0,    1, 32'h40,  mk(0, 2, 3,  32'h40,  4, 0, 0, 0, 0));
        issue(BEQ,   0,  0,    0, 32'h80,  mk(0, 2, 3,  32'h44,  5, 0, 0, 0, 0));
        issue(ADD,   2,  0,    0, 32'h0,   mk(0, 4, 6,  32'h48,  6, 1, 0, 0, 0));
        issue(JALR,  0,  0,    0, 32'h101, mk(0, 4, 4,  32'h100, 7, 1, 2, 1, 0));
        issue(JAL,   0,  0,    0, 32'h108, mk(0, 4, 4,  32'h108, 8, 1, 2, 1, 0));
        issue(BEQ,   0,  0,    1, 32'h42,  mk(1, 6, 4,  32'h108, 8, 0, 0, 0, 0));

        do_reset();
        issue(JAL,   0,  0,    0, 32'h102, mk(1, 6, 5,  32'h0,   0, 0, 0, 0, 0));

        do_reset();
        issue(ADDI,  14, 0,    0, 32'h0,   mk(0, 4, 18, 32'h4,   1, 1, 0, 1, 0));
        issue(ADDI,  1000, 0,  0, 32'h0,   mk(1, 6, 16, 32'h4,   1, 0, 0, 0, 0));

        do_reset();
        issue(ILLEG, 0,  0,    0, 32'h0,   mk(1, 6, 3,  32'h0,   0, 0, 0, 0, 0));

        do_reset();
        issue(ADDI,  0,  0,    0, 32'h0,   mk(0, 4, 4,  32'h4,   1, 1, 0, 1, 0));
        issue(ECALL, 0,  0,    0, 32'h0,   mk(1, 5, 3,  32'h4,   1, 0, 0, 0, 0));
        repeat (5) @(negedge clk);
        #1;
        chk("halt_state_held", {29'd0, state}, 32'd5);
        chk("halt_instret_frozen", instret, 32'd1);
        chk("halt_pc_frozen", pc, 32'h4);
        chk("halt_no_imem_req", {31'd0, imem_req}, 32'd0);

        do_reset();
        issue(ADDI,  0,  0,    0, 32'h0,   mk(0, 4, 4,  32'h4,   1, 1, 0, 1, 0));
        cur_instr = LW;
        cur_iwait = 0;
        cur_dwait = 1000;
        for (int i = 0; i < 50 && state != 3'd3; i++) @(negedge clk);
        chk("reached_mem", {29'd0, state}, 32'd3);
        chk("mem_dmem_req", {31'd0, dmem_req}, 32'd1);
        chk("mem_dmem_we_load", {31'd0, dmem_we}, 32'd0);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
